spi_master_ctrl: RTL and testbench
==================================

# spi_master_ctrl

Single-clock SPI master that turns host register-style requests into framed SPI transactions for the SPI slave + RAM wrapper. It sits directly upstream of that wrapper: it drives its `SS_n` and `MOSI`, samples its `MISO`, and returns read bytes to the host. Each request is a 2-bit op plus an 8-bit payload, serialised MSB-first as the 10-bit word the slave hands to the RAM. The master uses the slave's system clock, one bit per `clk` cycle.

## Interface
- `TURN`, default 2: idle cycles between the last MOSI bit and the first MISO sample of a read-data frame (range 1..7).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `cmd_valid`  in  1  host request valid.
- `cmd_ready`  out  1  master can accept a request; reset 0.
- `cmd_op`  in  2  00 write-addr, 01 write-data, 10 read-addr, 11 read-data.
- `cmd_data`  in  8  address or write byte; ignored for op 11.
- `rsp_valid`  out  1  one-cycle pulse, read byte valid; reset 0.
- `rsp_data`  out  8  read byte, held until next pulse; reset 0x00.
- `err`  out  1  one-cycle pulse, request rejected (macro only; tied 0 otherwise); reset 0.
- `SS_n`  out  1  slave select, active-low; reset 1.
- `MOSI`  out  1  serial data to slave; reset 0.
- `MISO`  in  1  serial data from slave.

## Operation
- States: IDLE, CMD, SHIFT, TURN, CAPT, END.
- IDLE: `cmd_ready`=1, `SS_n`=1. On `cmd_valid`: latch word = {cmd_op, cmd_data}, go to CMD.
- CMD (1 cycle): `SS_n`=0, `MOSI`=word[9] (the slave's write/read select bit).
- SHIFT (10 cycles): `MOSI`=word[9] down to word[0], one bit per cycle. A 4-bit counter runs 0..9. Exit to TURN if op=11, else to END.
- TURN (`TURN` cycles): `SS_n`=0, `MOSI`=0.
- CAPT (8 cycles): sample `MISO` at each rising edge and shift in MSB-first.
- END (1 cycle): `SS_n`=1, `MOSI`=0. For op 11, load `rsp_data` and pulse `rsp_valid` in this cycle. Then go to IDLE.
- `cmd_ready` is 0 in every state except IDLE. There is no request queue.
- `rst` in any state: IDLE on the next edge with `SS_n`=1, `MOSI`=0, counters cleared. The in-flight request is dropped with no `rsp_valid`. `rsp_data` is cleared. `cmd_ready`=0 in the reset cycle and 1 in the first cycle after.
- `MISO` is ignored outside CAPT.

## Timing
- The request is accepted at cycle T.
- `SS_n` falls at T+1. The CMD bit is driven at T+1. Word bits 9..0 are driven at T+2..T+11.
- Ops 00/01/10: END at T+12, IDLE (`cmd_ready`=1) at T+13. Period is 13 cycles per request.
- Op 11: TURN at T+12..T+11+TURN. MISO samples at T+12+TURN..T+19+TURN. END with `rsp_valid` at T+20+TURN, which is T+22 at default. Period is 21+TURN cycles.
- Between frames `SS_n` stays high for at least 2 cycles: END plus the IDLE accept cycle.
- All outputs are registered. `cmd_ready` is decoded from the registered state.

## Configuration
- `SPIM_SEQ_CHECK_EN` defined: the block tracks an "address armed" flag. The flag is set by a completed op 10 and cleared by a completed op 11 or by reset.
- With the macro, op 11 while the flag is clear is accepted but not sent: `SS_n` stays 1, `err` pulses at T+1, and IDLE returns at T+2.
- Without the macro there is no flag and no check, and `err` is constant 0.

## Structure
- Package `spi_master_pkg`:
  - op encodings `OP_WR_ADDR`/`OP_WR_DATA`/`OP_RD_ADDR`/`OP_RD_DATA`;
  - state enum;
  - `WORD_W`=10, `RD_W`=8.
  - The SPI slave should reuse the op encodings.
- One sub-module, `spim_shifter`: a parallel-load 10-bit MSB-first output shifter plus an 8-bit MSB-first input shifter, with load/shift enables driven by the FSM.

## Test plan
- Write-addr: op 00, data 0x3C -> MOSI over T+1..T+11 = 0,0,0,0,0,1,1,1,1,0,0; `SS_n` low T+1..T+11 and high at T+12; `cmd_ready` back at T+13.
- Write-data: op 01, data 0xA5, then read-addr 0x3C, then read-data against the real slave+RAM wrapper -> `rsp_valid` at T+22 of the op-11 request with `rsp_data`=0xA5.
- Read-data with a behavioural MISO model driving 0x5A at the CAPT cycles, TURN=3 -> `rsp_valid` at T+23, `rsp_data`=0x5A, no pulse at any other cycle.
- Back-to-back: `cmd_valid` held high with 3 queued write ops -> accepts at T, T+13 and T+26; `SS_n` high for exactly 2 cycles between frames.
- Reset at T+6 of a read-data frame -> `SS_n`=1, `MOSI`=0 at T+7; no `rsp_valid`; `rsp_data`=0x00; `cmd_ready`=1 at T+8.
- With `SPIM_SEQ_CHECK_EN`: op 11 after reset -> `err` pulse at T+1 and `SS_n` never falls. Op 10 then op 11 -> normal frame and `err` stays 0.

Source files
------------

// File: rtl/spi_master_pkg.sv
// Shared op encodings, FSM states and widths for the SPI master/slave pair.
// The SPI slave reuses the OP_* encodings so both ends agree on the frame.
package spi_master_pkg;

  localparam int WORD_W = 10;
  localparam int RD_W   = 8;

  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_SHIFT,
    S_TURN,
    S_CAPT,
    S_END
  } state_e;

endpackage

// File: rtl/spim_shifter.sv
// SPI master datapath: 10-bit MSB-first transmit shifter and
// 8-bit MSB-first receive shifter, sequenced by the controller FSM.
module spim_shifter
  import spi_master_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [WORD_W-1:0] word_i,
  input  logic              tx_shift_i,
  input  logic              rx_shift_i,
  input  logic              miso_i,
  output logic              mosi_o,
  output logic [RD_W-1:0]   rx_o
);

  logic [WORD_W-1:0] tx_q;
  logic [RD_W-1:0]   rx_q;

  // Zero fill means MOSI returns low once the last word bit is out.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tx_q <= '0;
      rx_q <= '0;
    end else begin
      if (load_i) begin
        tx_q <= word_i;
      end else if (tx_shift_i) begin
        tx_q <= {tx_q[WORD_W-2:0], 1'b0};
      end
      if (rx_shift_i) begin
        rx_q <= {rx_q[RD_W-2:0], miso_i};
      end
    end
  end

  assign mosi_o = tx_q[WORD_W-1];
  assign rx_o   = rx_q;

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: host op+byte requests become framed 10-bit SPI words.
// Optional SPIM_SEQ_CHECK_EN rejects read-data without a prior read-addr.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int TURN = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       err,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  localparam logic [3:0] TURN_LAST = 4'(TURN - 1);

  state_e          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [1:0]      op_q;
  logic            cmd_ready_q;
  logic            ss_n_q;
  logic            rsp_valid_q;
  logic [RD_W-1:0] rsp_data_q;
  logic [RD_W-1:0] rx;
  logic            accept;
  logic            reject;
  logic            capt_last;

  assign accept    = (state_q == S_IDLE) && cmd_ready_q && cmd_valid;
  assign capt_last = (state_q == S_CAPT) && (cnt_q == 4'd7);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) state_d = reject ? S_END : S_CMD;
      end
      S_CMD: begin
        cnt_d   = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        if (cnt_q == 4'd9) begin
          cnt_d   = '0;
          state_d = (op_q == OP_RD_DATA) ? S_TURN : S_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_TURN: begin
        if (cnt_q == TURN_LAST) begin
          cnt_d   = '0;
          state_d = S_CAPT;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_CAPT: begin
        if (cnt_q == 4'd7) begin
          cnt_d   = '0;
          state_d = S_END;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_END: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      op_q        <= '0;
      cmd_ready_q <= 1'b0;
      ss_n_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_ready_q <= (state_d == S_IDLE);
      ss_n_q      <= !(state_d inside {S_CMD, S_SHIFT, S_TURN, S_CAPT});
      rsp_valid_q <= capt_last;
      if (accept) op_q <= cmd_op;
      if (capt_last) rsp_data_q <= {rx[RD_W-2:0], MISO};
    end
  end

`ifdef SPIM_SEQ_CHECK_EN
  logic armed_q;
  logic err_q;

  assign reject = (cmd_op == OP_RD_DATA) && !armed_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      armed_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && reject;
      if (state_q == S_END) begin
        if (op_q == OP_RD_ADDR) begin
          armed_q <= 1'b1;
        end else if (op_q == OP_RD_DATA) begin
          armed_q <= 1'b0;
        end
      end
    end
  end

  assign err = err_q;
`else
  assign reject = 1'b0;
  assign err    = 1'b0;
`endif

  spim_shifter u_shifter (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (accept && !reject),
    .word_i     ({cmd_op, cmd_data}),
    .tx_shift_i (state_q == S_SHIFT),
    .rx_shift_i (state_q == S_CAPT),
    .miso_i     (MISO),
    .mosi_o     (MOSI),
    .rx_o       (rx)
  );

  assign cmd_ready = cmd_ready_q;
  assign SS_n      = ss_n_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Self-checking bench for spi_master_ctrl with a behavioural slave/RAM model.
// Build with SPIM_SEQ_CHECK_EN to also exercise the read-sequence check.
module tb_spi_master_ctrl;

  localparam int TB_TURN = 3;
`ifdef SPIM_SEQ_CHECK_EN
  localparam bit SEQ = 1'b1;
`else
  localparam bit SEQ = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       err;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;

  spi_master_ctrl #(.TURN(TB_TURN)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .err       (err),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Slave/RAM model state
  logic [7:0] mem [256];
  logic [7:0] wr_addr = 8'h00;
  logic [7:0] rd_addr = 8'h00;
  logic [7:0] cur_rsp = 8'h00;
  bit         armed   = 1'b0;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  data;
    logic [10:0] exp_mosi;
    logic [7:0]  exp_rsp;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One request starting at the negedge of an accepting cycle T; ends at
  // the negedge of the next accepting cycle.
  task automatic run_req(input logic [1:0] op, input logic [7:0] d,
                         output logic [10:0] seq, output logic [7:0] rsp);
    logic [10:0] ws;
    logic [7:0]  nb;
    logic [12:0] e;
    logic [12:0] a;
    bit          rej;
    bit          rd;
    int          len;
    int          c;
    ws  = {op[1], op, d};
    rej = SEQ && (op == 2'b11) && !armed;
    rd  = (op == 2'b11) && !rej;
    len = rej ? 1 : (rd ? 20 + TB_TURN : 12);
    nb  = mem[rd_addr];
    seq = '0;
    rsp = rsp_data;
    chk("ready_at_T", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_data  = d;
    for (int k = 1; k <= len + 1; k++) begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      c = k - (12 + TB_TURN);
      if (rd && c >= 0 && c < 8) MISO = nb[7-c];
      else MISO = 1'($urandom);
      @(negedge clk);
      e[12]  = (k >= len);
      e[11]  = (!rej && k <= 11) ? ws[11-k] : 1'b0;
      e[10]  = rd && (k == len);
      e[9]   = (k == len + 1);
      e[8]   = rej && (k == 1);
      e[7:0] = (rd && k >= len) ? nb : cur_rsp;
      a = {SS_n, MOSI, rsp_valid, cmd_ready, err, rsp_data};
      chk($sformatf("frame op%0d k%0d", op, k), 64'(a), 64'(e));
      if (k <= 11) seq[11-k] = MOSI;
      if (k == len) rsp = rsp_data;
    end
    case (op)
      2'b00: wr_addr = d;
      2'b01: mem[wr_addr] = d;
      2'b10: begin rd_addr = d; armed = 1'b1; end
      default: if (rd) begin cur_rsp = nb; armed = 1'b0; end
    endcase
  endtask

  initial begin
    logic [10:0] seq;
    logic [7:0]  rsp;
    logic [1:0]  bop [3];
    logic [7:0]  bd  [3];
    int          acc [3];
    int          nacc;
    int          idx;
    bit          took;
    logic [63:0] ss_act;
    logic [63:0] ss_exp;
    bit          bad;

    tbl[0] = '{2'b00, 8'h3C, 11'b00000111100, 8'h00};
    tbl[1] = '{2'b01, 8'hA5, 11'b00110100101, 8'h00};
    tbl[2] = '{2'b10, 8'h3C, 11'b11000111100, 8'h00};
    tbl[3] = '{2'b11, 8'h00, 11'b11100000000, 8'hA5};
    tbl[4] = '{2'b00, 8'hFF, 11'b00011111111, 8'h00};
    tbl[5] = '{2'b01, 8'h5A, 11'b00101011010, 8'h00};
    tbl[6] = '{2'b10, 8'hFF, 11'b11011111111, 8'h00};
    tbl[7] = '{2'b11, 8'h77, 11'b11101110111, 8'h5A};

    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_data = 8'h00;
    MISO = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'({SS_n, MOSI, rsp_valid, cmd_ready, err, rsp_data}),
        64'(13'b1_0000_0000_0000));
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("ready_reset_cycle", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    chk("ready_after_reset", 64'(cmd_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      run_req(tbl[i].op, tbl[i].data, seq, rsp);
      chk($sformatf("tbl%0d_mosi", i), 64'(seq), 64'(tbl[i].exp_mosi));
      if (tbl[i].op == 2'b11)
        chk($sformatf("tbl%0d_rsp", i), 64'(rsp), 64'(tbl[i].exp_rsp));
    end

    // Back-to-back writes with cmd_valid held high
    bop = '{2'b00, 2'b01, 2'b00};
    bd  = '{8'h11, 8'h22, 8'h33};
    idx = 0;
    nacc = 0;
    ss_act = '0;
    ss_exp = '0;
    cmd_valid = 1'b1;
    cmd_op = bop[0];
    cmd_data = bd[0];
    for (int k = 0; k < 40; k++) begin
      ss_act[k] = SS_n;
      ss_exp[k] = !((k % 13) >= 1 && (k % 13) <= 11);
      took = cmd_valid && cmd_ready;
      if (took && nacc < 3) begin
        acc[nacc] = k;
        nacc++;
      end
      @(posedge clk);
      #1;
      MISO = 1'($urandom);
      if (took) begin
        idx++;
        if (idx < 3) begin
          cmd_op = bop[idx];
          cmd_data = bd[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    chk("b2b_count", 64'(nacc), 64'd3);
    chk("b2b_acc1", 64'(acc[1]), 64'd13);
    chk("b2b_acc2", 64'(acc[2]), 64'd26);
    chk("b2b_ss_trace", ss_act, ss_exp);
    wr_addr = 8'h33;
    mem[8'h11] = 8'h22;

    // Reset in the middle of a read-data frame
    run_req(2'b10, 8'h11, seq, rsp);
    cmd_valid = 1'b1;
    cmd_op = 2'b11;
    cmd_data = 8'h00;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_frame", 64'({SS_n, MOSI, rsp_valid, cmd_ready, err, rsp_data}),
        64'(13'b1_0000_0000_0000));
    @(negedge clk);
    chk("rst_ready_back", 64'(cmd_ready), 64'd1);
    bad = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk);
      #1 MISO = 1'($urandom);
      @(negedge clk);
      if (rsp_valid || !SS_n) bad = 1'b1;
    end
    chk("rst_no_rsp", 64'(bad), 64'd0);
    armed = 1'b0;
    cur_rsp = 8'h00;

    // Read-data straight after reset, then a properly sequenced read
    run_req(2'b11, 8'h00, seq, rsp);
    run_req(2'b10, 8'h11, seq, rsp);
    run_req(2'b11, 8'h00, seq, rsp);
    chk("seq_read_rsp", 64'(rsp), 64'h22);

    // Randomised traffic against the model
    for (int i = 0; i < 40; i++) begin
      run_req(2'($urandom_range(0, 3)), 8'($urandom), seq, rsp);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
